// File: rtl/i2c_wb_cmd_sequencer.sv
// Purpose : Wishbone master that drives an iicmb_m_wb I2C controller through one
//           complete write transaction per request (bus select, start, address,
//           payload bytes, stop) and reports a completion status.
// Latency : 2 cycles per register access minimum (issue + ack), plus the core's
//           irq wait after every byte-level command; done_o one cycle after DONE.
// Backpressure: one request in flight (req_ready_o low from accept until the cycle
//           after done_o); payload bytes are pulled one at a time via data_ready_o
//           and the sequencer stalls with the bus idle while data_valid_i is low.
//
// Ports:
//   clk_i, rst_i                 clock, synchronous active-high reset
//   req_valid_i/req_ready_o      request handshake with req_bus_i/req_addr_i/req_len_i
//   data_valid_i/data_ready_o    payload byte handshake with data_i
//   done_o/status_o/busy_o       completion pulse, result code, in-progress flag
//   cyc_o/stb_o/we_o/adr_o/dat_o Wishbone master outputs; ack_i/dat_i inputs
//   irq_i                        controller interrupt, sampled as a level
//
// Optional feature: define I2C_SEQ_IRQ_TIMEOUT_EN to add an irq watchdog of
// TIMEOUT_CYCLES cycles that ends the transaction with status 4.

module i2c_wb_cmd_sequencer #(
    parameter int WB_ADDR_WIDTH  = 2,
    parameter int WB_DATA_WIDTH  = 8,
    parameter int I2C_ADDR_WIDTH = 7
`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 65535
`endif
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      req_valid_i,
    output logic                      req_ready_o,
    input  logic [3:0]                req_bus_i,
    input  logic [I2C_ADDR_WIDTH-1:0] req_addr_i,
    input  logic [5:0]                req_len_i,
    input  logic                      data_valid_i,
    output logic                      data_ready_o,
    input  logic [7:0]                data_i,
    output logic                      done_o,
    output logic [2:0]                status_o,
    output logic                      busy_o,
    output logic                      cyc_o,
    output logic                      stb_o,
    output logic                      we_o,
    output logic [WB_ADDR_WIDTH-1:0]  adr_o,
    output logic [WB_DATA_WIDTH-1:0]  dat_o,
    input  logic                      ack_i,
    input  logic [WB_DATA_WIDTH-1:0]  dat_i,
    input  logic                      irq_i
);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_EN_CORE   = 4'd1;
    localparam logic [3:0] S_BUS_DPR   = 4'd2;
    localparam logic [3:0] S_BUS_CMD   = 4'd3;
    localparam logic [3:0] S_START_CMD = 4'd4;
    localparam logic [3:0] S_ADDR_DPR  = 4'd5;
    localparam logic [3:0] S_ADDR_CMD  = 4'd6;
    localparam logic [3:0] S_DATA_WAIT = 4'd7;
    localparam logic [3:0] S_DATA_DPR  = 4'd8;
    localparam logic [3:0] S_DATA_CMD  = 4'd9;
    localparam logic [3:0] S_STOP_CMD  = 4'd10;
    localparam logic [3:0] S_WAIT_IRQ  = 4'd11;
    localparam logic [3:0] S_READ_CMDR = 4'd12;
    localparam logic [3:0] S_DONE      = 4'd13;

    localparam logic [WB_ADDR_WIDTH-1:0] A_CSR  = WB_ADDR_WIDTH'(0);
    localparam logic [WB_ADDR_WIDTH-1:0] A_DPR  = WB_ADDR_WIDTH'(1);
    localparam logic [WB_ADDR_WIDTH-1:0] A_CMDR = WB_ADDR_WIDTH'(2);

    localparam logic [WB_DATA_WIDTH-1:0] CSR_ENABLE  = WB_DATA_WIDTH'(8'hC0);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_SET_BUS = WB_DATA_WIDTH'(8'h06);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_START   = WB_DATA_WIDTH'(8'h04);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_WRITE   = WB_DATA_WIDTH'(8'h01);
    localparam logic [WB_DATA_WIDTH-1:0] CMD_STOP    = WB_DATA_WIDTH'(8'h05);

    logic [3:0]                state;
    logic [3:0]                ret_state;
    logic                      core_en;
    logic [3:0]                bus_q;
    logic [I2C_ADDR_WIDTH-1:0] addr_q;
    logic [5:0]                remaining;
    logic [7:0]                byte_q;

    logic                      acc_req;
    logic                      acc_we;
    logic [WB_ADDR_WIDTH-1:0]  acc_adr;
    logic [WB_DATA_WIDTH-1:0]  acc_dat;
    logic                      ack_evt;

    // CMDR command-code field is echoed back on reads but only the flags matter.
    logic                      cmdr_code_unused;
    assign cmdr_code_unused = ^dat_i[3:0];

`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
    logic [15:0] tmo_cnt;
`endif

    assign data_ready_o = (state == S_DATA_WAIT);
    assign ack_evt      = cyc_o && ack_i;

    // Register access owed by the current state; issued once while the bus is idle.
    always_comb begin
        acc_req = 1'b0;
        acc_we  = 1'b1;
        acc_adr = A_CSR;
        acc_dat = '0;
        case (state)
            S_EN_CORE:   begin acc_req = 1'b1; acc_adr = A_CSR;  acc_dat = CSR_ENABLE; end
            S_BUS_DPR:   begin acc_req = 1'b1; acc_adr = A_DPR;  acc_dat = WB_DATA_WIDTH'(bus_q); end
            S_BUS_CMD:   begin acc_req = 1'b1; acc_adr = A_CMDR; acc_dat = CMD_SET_BUS; end
            S_START_CMD: begin acc_req = 1'b1; acc_adr = A_CMDR; acc_dat = CMD_START; end
            S_ADDR_DPR:  begin acc_req = 1'b1; acc_adr = A_DPR;  acc_dat = WB_DATA_WIDTH'({addr_q, 1'b0}); end
            S_ADDR_CMD,
            S_DATA_CMD:  begin acc_req = 1'b1; acc_adr = A_CMDR; acc_dat = CMD_WRITE; end
            S_DATA_DPR:  begin acc_req = 1'b1; acc_adr = A_DPR;  acc_dat = WB_DATA_WIDTH'(byte_q); end
            S_STOP_CMD:  begin acc_req = 1'b1; acc_adr = A_CMDR; acc_dat = CMD_STOP; end
            S_READ_CMDR: begin acc_req = 1'b1; acc_we = 1'b0;    acc_adr = A_CMDR; end
            default:     ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state       <= S_IDLE;
            ret_state   <= S_IDLE;
            core_en     <= 1'b0;
            bus_q       <= '0;
            addr_q      <= '0;
            remaining   <= '0;
            byte_q      <= '0;
            req_ready_o <= 1'b1;
            done_o      <= 1'b0;
            status_o    <= 3'd0;
            busy_o      <= 1'b0;
            cyc_o       <= 1'b0;
            stb_o       <= 1'b0;
            we_o        <= 1'b0;
            adr_o       <= '0;
            dat_o       <= '0;
`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
            tmo_cnt     <= '0;
`endif
        end else begin
            done_o <= 1'b0;

            // Every access state leaves on its ack, so an idle bus in an access
            // state always means its access has not been issued yet; this also
            // guarantees one idle cycle between back-to-back accesses.
            if (acc_req && !cyc_o) begin
                cyc_o <= 1'b1;
                stb_o <= 1'b1;
                we_o  <= acc_we;
                adr_o <= acc_adr;
                dat_o <= acc_dat;
            end else if (ack_evt) begin
                cyc_o <= 1'b0;
                stb_o <= 1'b0;
                we_o  <= 1'b0;
                adr_o <= '0;
                dat_o <= '0;
            end

            case (state)
                S_IDLE: begin
                    req_ready_o <= 1'b1;
                    if (req_valid_i && req_ready_o) begin
                        bus_q       <= req_bus_i;
                        addr_q      <= req_addr_i;
                        remaining   <= req_len_i;
                        req_ready_o <= 1'b0;
                        busy_o      <= 1'b1;
                        status_o    <= 3'd0;
                        state       <= core_en ? S_BUS_DPR : S_EN_CORE;
                    end
                end
                S_EN_CORE: if (ack_evt) begin
                    core_en <= 1'b1;
                    state   <= S_BUS_DPR;
                end
                S_BUS_DPR:  if (ack_evt) state <= S_BUS_CMD;
                S_ADDR_DPR: if (ack_evt) state <= S_ADDR_CMD;
                S_DATA_DPR: if (ack_evt) state <= S_DATA_CMD;
                S_BUS_CMD, S_START_CMD, S_ADDR_CMD, S_DATA_CMD, S_STOP_CMD: if (ack_evt) begin
                    state <= S_WAIT_IRQ;
`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                    case (state)
                        S_BUS_CMD:   ret_state <= S_START_CMD;
                        S_START_CMD: ret_state <= S_ADDR_DPR;
                        S_STOP_CMD:  ret_state <= S_DONE;
                        default:     ret_state <= (remaining == 6'd0) ? S_STOP_CMD : S_DATA_WAIT;
                    endcase
                end
                S_DATA_WAIT: if (data_valid_i) begin
                    byte_q    <= data_i;
                    remaining <= remaining - 6'd1;
                    state     <= S_DATA_DPR;
                end
                S_WAIT_IRQ: begin
                    if (irq_i) begin
                        state <= S_READ_CMDR;
`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        // Core state is unknown after a hang; force CSR rewrite next time.
                        status_o <= 3'd4;
                        core_en  <= 1'b0;
                        state    <= S_DONE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
`endif
                    end
                end
                S_READ_CMDR: if (ack_evt) begin
                    if (ret_state == S_DONE) begin
                        // Stop readback never overrides an earlier result.
                        state <= S_DONE;
                    end else if (dat_i[5]) begin
                        status_o <= 3'd2;
                        state    <= S_DONE;
                    end else if (dat_i[4]) begin
                        status_o <= 3'd3;
                        state    <= S_DONE;
                    end else if (dat_i[6]) begin
                        status_o <= 3'd1;
                        state    <= S_STOP_CMD;
                    end else if (dat_i[7]) begin
                        state <= ret_state;
                    end else begin
                        // No completion flag at all: the core is not behaving.
                        status_o <= 3'd3;
                        state    <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_o <= 1'b1;
                    busy_o <= 1'b0;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_wb_cmd_sequencer.sv
// Bench for i2c_wb_cmd_sequencer: directed requests against a small iicmb core
// model, Wishbone accesses and completion statuses checked by a scoreboard.
// Build with I2C_SEQ_IRQ_TIMEOUT_EN defined to exercise the irq watchdog.

module tb_i2c_wb_cmd_sequencer;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_i;
    logic       req_valid_i, req_ready_o;
    logic [3:0] req_bus_i;
    logic [6:0] req_addr_i;
    logic [5:0] req_len_i;
    logic       data_valid_i, data_ready_o;
    logic [7:0] data_i;
    logic       done_o, busy_o;
    logic [2:0] status_o;
    logic       cyc_o, stb_o, we_o;
    logic [1:0] adr_o;
    logic [7:0] dat_o;
    logic       ack_i, irq_i;
    logic [7:0] dat_i;

`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
    i2c_wb_cmd_sequencer #(.TIMEOUT_CYCLES(100)) dut (
`else
    i2c_wb_cmd_sequencer dut (
`endif
        .clk_i(clk), .rst_i(rst_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_bus_i(req_bus_i), .req_addr_i(req_addr_i), .req_len_i(req_len_i),
        .data_valid_i(data_valid_i), .data_ready_o(data_ready_o), .data_i(data_i),
        .done_o(done_o), .status_o(status_o), .busy_o(busy_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .dat_o(dat_o),
        .ack_i(ack_i), .dat_i(dat_i), .irq_i(irq_i)
    );

    typedef struct packed {
        logic       we;
        logic [1:0] adr;
        logic [7:0] dat;
    } wb_t;

    wb_t        exp_wb[$];
    logic [2:0] exp_st[$];
    logic [7:0] data_q[$];
    int         checks = 0;
    int         failures = 0;
    int         done_cnt = 0;
    bit         al_mode = 0;
    bit         block_irq = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Expected-access helpers
    task automatic ew(input logic [1:0] a, input logic [7:0] d);
        exp_wb.push_back(wb_t'({1'b1, a, d}));
    endtask
    task automatic er();
        exp_wb.push_back(wb_t'({1'b0, 2'd2, 8'h00}));
    endtask
    task automatic exp_head(input bit csr, input logic [3:0] bus, input logic [6:0] addr);
        if (csr) ew(2'd0, 8'hC0);
        ew(2'd1, {4'h0, bus});
        ew(2'd2, 8'h06); er();
        ew(2'd2, 8'h04); er();
        ew(2'd1, {addr, 1'b0});
        ew(2'd2, 8'h01); er();
    endtask
    task automatic exp_byte(input logic [7:0] b);
        ew(2'd1, b); ew(2'd2, 8'h01); er();
    endtask
    task automatic exp_stop();
        ew(2'd2, 8'h05); er();
    endtask

    // iicmb core model: acks in the stb cycle, raises irq a few cycles after a
    // CMDR command, clears it on the CMDR read.
    logic [7:0] resp, dpr;
    int         irq_cnt;
    bit         addr_next;
    initial begin
        ack_i = 0; dat_i = 0; irq_i = 0; resp = 0; dpr = 0; irq_cnt = -1; addr_next = 0;
        forever begin
            @(posedge clk); #1;
            if (rst_i) begin
                ack_i = 0; irq_i = 0; irq_cnt = -1; addr_next = 0;
            end else begin
                if (cyc_o && stb_o && !ack_i) begin
                    ack_i = 1;
                    if (!we_o && adr_o == 2'd2) begin
                        dat_i = resp;
                        irq_i = 0;
                    end else if (we_o && adr_o == 2'd2) begin
                        resp = 8'h80;
                        if (dat_o == 8'h04) begin
                            addr_next = 1;
                            if (al_mode) resp = 8'h20;
                        end else if (dat_o == 8'h01 && addr_next) begin
                            addr_next = 0;
                            if (dpr == 8'hFE) resp = 8'h40;
                        end
                        if (!(block_irq && dat_o == 8'h06)) irq_cnt = 3;
                    end else if (we_o && adr_o == 2'd1) begin
                        dpr = dat_o;
                    end
                end else begin
                    ack_i = 0;
                end
                if (irq_cnt > 0) irq_cnt--;
                else if (irq_cnt == 0) begin irq_i = 1; irq_cnt = -1; end
            end
        end
    end

    // Payload source: presents data_q head; pops when a handshake lands.
    initial begin
        bit hs;
        data_valid_i = 0; data_i = 0;
        forever begin
            @(negedge clk);
            data_valid_i = (data_q.size() > 0);
            if (data_q.size() > 0) data_i = data_q[0];
            hs = data_valid_i && data_ready_o;
            @(posedge clk);
            if (hs) void'(data_q.pop_front());
        end
    end

    // Monitor: completed Wishbone accesses and completion pulses.
    initial begin
        wb_t e;
        logic [2:0] es;
        forever begin
            @(negedge clk);
            if (cyc_o && stb_o && ack_i) begin
                checks++;
                if (exp_wb.size() == 0) begin
                    failures++;
                    $display("FAIL wb_unexpected actual we=%0d adr=%0d dat=%02h required no access", we_o, adr_o, dat_o);
                end else begin
                    e = exp_wb.pop_front();
                    if (we_o !== e.we || adr_o !== e.adr || (e.we && dat_o !== e.dat)) begin
                        failures++;
                        $display("FAIL wb_access actual we=%0d adr=%0d dat=%02h required we=%0d adr=%0d dat=%02h",
                                 we_o, adr_o, dat_o, e.we, e.adr, e.dat);
                    end
                end
            end
            if (done_o) begin
                done_cnt++;
                chk("busy_low_at_done", busy_o, 0);
                checks++;
                if (exp_st.size() == 0) begin
                    failures++;
                    $display("FAIL done_unexpected actual status=%0d required no done", status_o);
                end else begin
                    es = exp_st.pop_front();
                    if (status_o !== es) begin
                        failures++;
                        $display("FAIL status actual=%0d required=%0d", status_o, es);
                    end
                end
            end
        end
    end

    task automatic send_req(input logic [3:0] b, input logic [6:0] a, input logic [5:0] n);
        @(negedge clk);
        req_bus_i = b; req_addr_i = a; req_len_i = n; req_valid_i = 1;
        for (int i = 0; i < 200 && !req_ready_o; i++) @(negedge clk);
        if (!req_ready_o) begin
            checks++; failures++;
            $display("FAIL req_accept actual ready=0 required ready=1 within 200 cycles");
        end
        @(posedge clk); #1;
        req_valid_i = 0;
        chk("busy_after_accept", busy_o, 1);
    endtask

    task automatic wait_done(input int budget);
        int start;
        int i;
        start = done_cnt;
        i = 0;
        while (done_cnt == start && i < budget) begin
            @(negedge clk);
            i++;
        end
        if (done_cnt == start) begin
            checks++; failures++;
            $display("FAIL done_timeout actual no done required done within %0d cycles", budget);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog actual still running required finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        rst_i = 1; req_valid_i = 0; req_bus_i = 0; req_addr_i = 0; req_len_i = 0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", req_ready_o, 1);
        chk("rst_busy", busy_o, 0);
        chk("rst_done", done_o, 0);
        chk("rst_cyc_stb_we", {cyc_o, stb_o, we_o}, 0);
        chk("rst_adr_dat", {adr_o, dat_o}, 0);
        chk("rst_status", status_o, 0);
        chk("rst_data_ready", data_ready_o, 0);
        rst_i = 0;

        // 1: first request enables the core
        exp_head(1, 4'd0, 7'h22); exp_byte(8'h78); exp_byte(8'h08); exp_stop();
        exp_st.push_back(3'd0);
        data_q.push_back(8'h78); data_q.push_back(8'h08);
        send_req(4'd0, 7'h22, 6'd2);
        wait_done(2000);
        chk("t1_wb_drained", exp_wb.size(), 0);

        // 2: back-to-back, 32 bytes, no CSR rewrite
        exp_head(0, 4'd5, 7'h22);
        for (int i = 0; i < 32; i++) begin
            exp_byte(8'(i));
            data_q.push_back(8'(i));
        end
        exp_stop();
        exp_st.push_back(3'd0);
        send_req(4'd5, 7'h22, 6'd32);
        wait_done(5000);
        chk("t2_wb_drained", exp_wb.size(), 0);

        // 3: address NAK, payload left untouched, Stop still sent
        exp_head(0, 4'd1, 7'h7F); exp_stop();
        exp_st.push_back(3'd1);
        data_q.push_back(8'hA1); data_q.push_back(8'hA2); data_q.push_back(8'hA3);
        send_req(4'd1, 7'h7F, 6'd3);
        wait_done(2000);
        chk("t3_wb_drained", exp_wb.size(), 0);
        chk("t3_bytes_left", data_q.size(), 3);
        data_q.delete();

        // 4: arbitration lost after Start, no Stop
        al_mode = 1;
        ew(2'd1, 8'h02); ew(2'd2, 8'h06); er(); ew(2'd2, 8'h04); er();
        exp_st.push_back(3'd2);
        data_q.push_back(8'hAA);
        send_req(4'd2, 7'h10, 6'd1);
        wait_done(2000);
        al_mode = 0;
        repeat (5) @(negedge clk);
        chk("t4_wb_drained", exp_wb.size(), 0);
        chk("t4_bytes_left", data_q.size(), 1);
        data_q.delete();

        // 5: irq never arrives after Set Bus
        block_irq = 1;
        ew(2'd1, 8'h03); ew(2'd2, 8'h06);
`ifdef I2C_SEQ_IRQ_TIMEOUT_EN
        exp_st.push_back(3'd4);
        send_req(4'd3, 7'h33, 6'd0);
        wait_done(400);
        block_irq = 0;
`else
        saved = done_cnt;
        send_req(4'd3, 7'h33, 6'd0);
        repeat (400) @(negedge clk);
        chk("t5_busy_stuck", busy_o, 1);
        chk("t5_no_done", done_cnt, saved);
        rst_i = 1;
        @(posedge clk); #1;
        chk("t5_rst_cyc_stb", {cyc_o, stb_o}, 0);
        @(negedge clk);
        rst_i = 0;
        block_irq = 0;
`endif
        chk("t5_wb_drained", exp_wb.size(), 0);

        // 6: reset during the 3rd data byte; core_en must be cleared
        exp_head(1, 4'd0, 7'h22); exp_byte(8'h11); exp_byte(8'h22); ew(2'd1, 8'h33);
        data_q.push_back(8'h11); data_q.push_back(8'h22);
        data_q.push_back(8'h33); data_q.push_back(8'h44);
        send_req(4'd0, 7'h22, 6'd4);
        begin
            int i;
            i = 0;
            while (!(data_q.size() == 1 && cyc_o && stb_o) && i < 2000) begin
                @(negedge clk);
                i++;
            end
            if (i >= 2000) begin
                checks++; failures++;
                $display("FAIL t6_reach_byte3 actual not reached required 3rd byte access within 2000 cycles");
            end
        end
        rst_i = 1;
        @(posedge clk); #1;
        chk("t6_rst_cyc_stb", {cyc_o, stb_o}, 0);
        chk("t6_rst_req_ready", req_ready_o, 1);
        chk("t6_rst_busy", busy_o, 0);
        @(negedge clk);
        rst_i = 0;
        chk("t6_wb_drained", exp_wb.size(), 0);
        data_q.delete();

        // 7: after reset (or timeout) the CSR is written again
        exp_head(1, 4'd0, 7'h22); exp_byte(8'h5A); exp_stop();
        exp_st.push_back(3'd0);
        data_q.push_back(8'h5A);
        send_req(4'd0, 7'h22, 6'd1);
        wait_done(2000);
        chk("t7_wb_drained", exp_wb.size(), 0);

        repeat (5) @(negedge clk);
        chk("status_drained", exp_st.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/i2c_wb_cmd_sequencer.md
# i2c_wb_cmd_sequencer

Hardware Wishbone master that sits directly upstream of the `iicmb_m_wb` I2C multi-bus controller and drives its register interface. It accepts one write transaction per request: bus id, 7-bit slave address and a byte stream. It issues the required CSR, DPR and CMDR register sequence, waits on `irq` after every byte-level command, and reads back CMDR. It reports a completion status, replacing the task-based Wishbone driving in the bench with synthesizable control.

## Interface
- WB_ADDR_WIDTH, 2, Wishbone address width.
- WB_DATA_WIDTH, 8, Wishbone data width.
- I2C_ADDR_WIDTH, 7, slave address width.
- TIMEOUT_CYCLES, 65535, irq watchdog limit; used only with the macro.

- clk_i  in  1  clock.
- rst_i  in  1  reset; synchronous, active-high.
- req_valid_i / req_ready_o  in/out  1  request handshake; transfer when both are high.
- req_bus_i  in  4  I2C bus id.
- req_addr_i  in  I2C_ADDR_WIDTH  slave address.
- req_len_i  in  6  byte count, 0..32; 0 means address phase only.
- data_valid_i / data_ready_o  in/out  1  payload byte handshake.
- data_i  in  8  payload byte.
- done_o  out  1  one-cycle completion pulse.
- status_o  out  3  result, valid while `done_o` is high: 0 OK, 1 NAK, 2 ARB_LOST, 3 ERR, 4 TIMEOUT.
- busy_o  out  1  high from request accept until `done_o`.
- cyc_o, stb_o, we_o  out  1  Wishbone master controls.
- adr_o  out  WB_ADDR_WIDTH  register select: 0 CSR, 1 DPR, 2 CMDR.
- dat_o  out  8  write data.
- ack_i  in  1  Wishbone ack.
- dat_i  in  8  read data.
- irq_i  in  1  core interrupt.

## Operation
- Reset values: `req_ready_o`=1; `data_ready_o`, `done_o`, `busy_o`, `cyc_o`, `stb_o`, `we_o`=0; `adr_o`, `dat_o`, `status_o`=0. The internal `core_en` flag clears.
- Request accept latches bus, address and len. `req_ready_o` stays low until the cycle after `done_o`.
- Register accesses issued for a request, in order:
  1. CSR=0xC0, only if `core_en`=0; then set `core_en`.
  2. DPR=bus.
  3. CMDR=0x06 (Set Bus), then wait for irq and read CMDR.
  4. CMDR=0x04 (Start), then wait for irq and read CMDR.
  5. DPR={addr,1'b0}.
  6. CMDR=0x01, then wait for irq and read CMDR.
  7. For each of len bytes: DATA_WAIT (`data_ready_o`=1 until handshake), DPR=byte, CMDR=0x01, wait for irq, read CMDR.
  8. CMDR=0x05 (Stop), then wait for irq and read CMDR.
  9. DONE.
- States: IDLE, EN_CORE, BUS_DPR, BUS_CMD, START_CMD, ADDR_DPR, ADDR_CMD, DATA_WAIT, DATA_DPR, DATA_CMD, STOP_CMD, WAIT_IRQ, READ_CMDR, DONE. WAIT_IRQ and READ_CMDR are shared states with a registered return state.
- READ_CMDR decode, priority AL(bit5) > ERR(bit4) > NAK(bit6) > DON(bit7):
  - AL: status 2, go directly to DONE with no Stop.
  - ERR: status 3, go to DONE.
  - NAK: status 1, go to STOP_CMD, skipping the remaining bytes. Any bytes not yet taken are left in the upstream source.
  - DON: continue the sequence.
  - On the Stop readback, any non-DON result keeps the earlier status.
- DATA_WAIT stalls indefinitely with no Wishbone activity while `data_valid_i` is low.
- Reset mid-operation: next edge restores all reset values, drops `cyc_o`/`stb_o` and clears `core_en`. An in-flight I2C transfer is abandoned.

## Timing
- Wishbone access:
  - `cyc_o`/`stb_o`/`we_o`/`adr_o`/`dat_o` are registered and asserted the cycle after the access state is entered.
  - They are held stable until `ack_i` is sampled high, and deasserted on the following cycle.
  - Read data is captured on the ack cycle.
  - There is at least one idle cycle between accesses.
- WAIT_IRQ samples `irq_i` as a level; leaving it on the first high sample starts the CMDR read next cycle.
- `done_o` is asserted the cycle after the DONE state is entered. `busy_o` falls with `done_o`.
- Minimum request-to-done latency, excluding irq waits and with `ack_i` one cycle after `stb_o`, is 2 cycles per access.

## Configuration
- `I2C_SEQ_IRQ_TIMEOUT_EN` defined:
  - A 16-bit counter clears on WAIT_IRQ entry and counts while `irq_i`=0.
  - On reaching TIMEOUT_CYCLES: status 4, `core_en` cleared so the next request rewrites CSR, and go to DONE with no Stop.
- Undefined: no counter; WAIT_IRQ waits indefinitely and status 4 is never produced.

## Test plan
- Bus 0, addr 0x22, len 2, bytes 0x78, 0x08 -> Wishbone writes CSR C0, DPR 00, CMDR 06, CMDR 04, DPR 44, CMDR 01, DPR 78, CMDR 01, DPR 08, CMDR 01, CMDR 05, each CMDR write followed by a CMDR read; status 0; I2C monitor shows WRITE addr 0x22 data 0x78, 0x08.
- Back-to-back request, len 32, bytes 0..31 -> no CSR write; 32 data writes; I2C monitor shows data 0..31; status 0.
- Address 0x7F with no responding slave -> NAK on address; no DPR data writes; Stop issued; status 1.
- Core model returns CMDR 0x20 after Start -> status 2; no Stop written.
- `irq_i` forced low after Set Bus, with the macro and TIMEOUT_CYCLES=100 -> `done_o` with status 4 after 100 cycles. Without the macro, `busy_o` stays high.
- `rst_i` pulsed during the 3rd data byte -> `cyc_o`/`stb_o` low next cycle, `req_ready_o`=1; the next request begins with CSR=0xC0.
